// File: rtl/alu_op_sequencer_if.sv
// Operand, control and display-select signals between the ALU op sequencer and its host.
// The slave modport is the sequencer side, and the master modport is the host side.
interface alu_op_sequencer_if;
    logic [2:0] Num_A_in;
    logic [2:0] Num_B_in;
    logic       start_in;
    logic       abort_in;
    logic       man_in;
    logic       step_in;
    logic [2:0] Num_A_out;
    logic [2:0] Num_B_out;
    logic [1:0] Sel_A_out;
    logic       Sel_M_out;
    logic       busy_out;
    logic       done_out;
    logic [2:0] phase_out;

    modport slave (
        input  Num_A_in, Num_B_in, start_in, abort_in, man_in, step_in,
        output Num_A_out, Num_B_out, Sel_A_out, Sel_M_out, busy_out, done_out, phase_out
    );

    modport master (
        output Num_A_in, Num_B_in, start_in, abort_in, man_in, step_in,
        input  Num_A_out, Num_B_out, Sel_A_out, Sel_M_out, busy_out, done_out, phase_out
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Steps the 3-bit ALU through all four operations, showing each result in octal and then in Gray.
// Each display phase is held for DWELL cycles in auto mode, or advanced by step pulses in manual mode.
module alu_op_sequencer #(
    parameter int unsigned DWELL = 8
) (
    input logic              clk_in,
    input logic              rst_in,
    alu_op_sequencer_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] num_a_q, num_a_d;
    logic [2:0] num_b_q, num_b_d;
    logic       step_q;
    logic       step_rise;
    logic       advance;

    assign step_rise = bus.step_in & ~step_q;

    // NOTE: every next-state signal gets a default at the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        num_a_d = num_a_q;
        num_b_d = num_b_q;
        advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_in && !bus.abort_in) begin
                    state_d = ST_RUN;
                    phase_d = 3'd0;
                    cnt_d   = 8'd0;
                    num_a_d = bus.Num_A_in;
                    num_b_d = bus.Num_B_in;
                end
            end

            ST_RUN: begin
                if (bus.abort_in) begin
                    state_d = ST_IDLE;
                    phase_d = 3'd0;
                    cnt_d   = 8'd0;
                end else begin
                    // Manual mode pins the counter at zero so that a later return to auto mode dwells a full period.
                    if (bus.man_in) begin
                        cnt_d   = 8'd0;
                        advance = step_rise;
                    end else if (cnt_q == DWELL_LAST) begin
                        cnt_d   = 8'd0;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end

                    if (advance) begin
                        if (phase_q == 3'd7) begin
                            state_d = ST_DONE;
                        end else begin
                            phase_d = phase_q + 3'd1;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.abort_in) begin
                    phase_d = 3'd0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments, so every flop samples the pre-edge value of the others.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            phase_q <= 3'd0;
            cnt_q   <= 8'd0;
            num_a_q <= 3'd0;
            num_b_q <= 3'd0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            num_a_q <= num_a_d;
            num_b_q <= num_b_d;
            step_q  <= bus.step_in;
        end
    end

    // Outputs are decoded straight from registers, so an asynchronous reset clears them immediately.
    assign bus.Num_A_out = num_a_q;
    assign bus.Num_B_out = num_b_q;
    assign bus.Sel_A_out = phase_q[2:1];
    assign bus.Sel_M_out = phase_q[0];
    assign bus.phase_out = phase_q;
    assign bus.busy_out  = (state_q == ST_RUN);
    assign bus.done_out  = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with DWELL = 4.
// It covers auto and manual stepping, operand isolation, abort and contention, and asynchronous reset.
module tb_alu_op_sequencer;
    localparam int DW = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic [13:0] outs;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.DWELL(DW)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    assign outs = {bus.Num_A_out, bus.Num_B_out, bus.Sel_A_out, bus.Sel_M_out,
                   bus.busy_out, bus.done_out, bus.phase_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_phase(input string tag, input int ph);
        check({tag, " phase"}, int'(bus.phase_out), ph);
        check({tag, " sel_a"}, int'(bus.Sel_A_out), ph / 2);
        check({tag, " sel_m"}, int'(bus.Sel_M_out), ph % 2);
    endtask

    // Full auto sequence. With isolate set, a new operand and a start pulse are applied during phase 3.
    task automatic auto_seq(input logic [2:0] a, input logic [2:0] b, input bit isolate);
        bus.Num_A_in = a;
        bus.Num_B_in = b;
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        check("auto accept busy", int'(bus.busy_out), 1);
        check("auto accept opa", int'(bus.Num_A_out), int'(a));
        check("auto accept opb", int'(bus.Num_B_out), int'(b));
        for (int k = 0; k < 8 * DW; k++) begin
            check_phase("auto run", k / DW);
            check("auto run busy", int'(bus.busy_out), 1);
            check("auto run done", int'(bus.done_out), 0);
            check("auto run opa", int'(bus.Num_A_out), int'(a));
            if (isolate && k == 3 * DW) begin
                bus.Num_A_in = 3'd7;
                bus.start_in = 1'b1;
            end else begin
                bus.start_in = 1'b0;
            end
            tick();
        end
        check("auto done pulse", int'(bus.done_out), 1);
        check("auto done busy", int'(bus.busy_out), 0);
        check_phase("auto done hold", 7);
        check("auto done opa", int'(bus.Num_A_out), int'(a));
        tick();
        check("auto idle done", int'(bus.done_out), 0);
        check("auto idle busy", int'(bus.busy_out), 0);
        check_phase("auto idle hold", 7);
        check("auto idle opb", int'(bus.Num_B_out), int'(b));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.Num_A_in = 3'd0;
        bus.Num_B_in = 3'd0;
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;
        bus.man_in   = 1'b0;
        bus.step_in  = 1'b0;
        #1;
        check("reset outs", int'(outs), 0);
        tick();
        tick();
        #2 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle outs", int'(outs), 0);
        end

        auto_seq(3'd5, 3'd3, 1'b1);

        // Manual stepping.
        bus.man_in = 1'b1;
        bus.Num_A_in = 3'd2;
        bus.Num_B_in = 3'd6;
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        check("man accept busy", int'(bus.busy_out), 1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("man hold phase", int'(bus.phase_out), 0);
        end
        bus.step_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("man step held", int'(bus.phase_out), 1);
        end
        bus.step_in = 1'b0;
        tick();
        for (int p = 2; p <= 8; p++) begin
            bus.step_in = 1'b1;
            tick();
            if (p < 8) begin
                check_phase("man step", p);
                check("man step done", int'(bus.done_out), 0);
            end else begin
                check("man last done", int'(bus.done_out), 1);
                check("man last busy", int'(bus.busy_out), 0);
            end
            bus.step_in = 1'b0;
            tick();
        end
        check("man after done", int'(bus.done_out), 0);
        check("man opa", int'(bus.Num_A_out), 2);
        bus.man_in = 1'b0;

        // Auto to manual and back mid-phase: the dwell restarts from zero.
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        tick();
        tick();
        bus.man_in = 1'b1;
        tick();
        tick();
        tick();
        bus.man_in = 1'b0;
        for (int i = 0; i < DW - 1; i++) begin
            tick();
            check("switch hold phase", int'(bus.phase_out), 0);
        end
        tick();
        check("switch advance", int'(bus.phase_out), 1);
        bus.abort_in = 1'b1;
        tick();
        bus.abort_in = 1'b0;
        check("switch abort busy", int'(bus.busy_out), 0);

        // Abort during phase 4.
        bus.Num_A_in = 3'd1;
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        for (int i = 0; i < 4 * DW; i++) tick();
        check("abort pre phase", int'(bus.phase_out), 4);
        bus.abort_in = 1'b1;
        tick();
        bus.abort_in = 1'b0;
        check("abort busy", int'(bus.busy_out), 0);
        check_phase("abort", 0);
        check("abort opa kept", int'(bus.Num_A_out), 1);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("abort no done", int'({bus.done_out, bus.busy_out}), 0);
        end
        bus.start_in = 1'b1;
        bus.abort_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        bus.abort_in = 1'b0;
        check("contention busy", int'(bus.busy_out), 0);
        tick();
        check("contention idle", int'(bus.busy_out), 0);

        // Asynchronous reset at phase 5 with the counter at 2.
        bus.Num_A_in = 3'd4;
        bus.Num_B_in = 3'd1;
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        for (int i = 0; i < 5 * DW + 2; i++) tick();
        check("pre reset phase", int'(bus.phase_out), 5);
        #2 rst = 1'b1;
        #1;
        check("async reset outs", int'(outs), 0);
        tick();
        check("reset held outs", int'(outs), 0);
        #2 rst = 1'b0;
        tick();
        check("post reset outs", int'(outs), 0);
        auto_seq(3'd6, 3'd2, 1'b0);

        // Start held through DONE re-launches on the first idle edge with fresh operands.
        bus.Num_A_in = 3'd1;
        bus.Num_B_in = 3'd2;
        bus.start_in = 1'b1;
        tick();
        for (int i = 0; i < 8 * DW; i++) tick();
        check("held done", int'(bus.done_out), 1);
        bus.Num_A_in = 3'd3;
        tick();
        check("held idle busy", int'(bus.busy_out), 0);
        tick();
        check("held restart busy", int'(bus.busy_out), 1);
        check("held restart phase", int'(bus.phase_out), 0);
        check("held restart opa", int'(bus.Num_A_out), 3);
        bus.start_in = 1'b0;
        bus.abort_in = 1'b1;
        tick();
        bus.abort_in = 1'b0;
        check("final idle", int'(bus.busy_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Controller that sequences the 3-bit ALU / dual-decoder display datapath.
- On start, it captures operands A and B and steps through all four ALU operations.
- For each operation it shows the result first in octal, then in Gray form, for a programmable dwell time.
- It drives the ALU operation select, display mux select and latched operands. An optional manual mode advances one display phase per step pulse.

Parameters:
DWELL, 8, clock cycles each display phase is held in auto mode; legal range 1..255; counter width 8 bits.

Ports:
clk_in  input  1  system clock, rising edge active
rst_in  input  1  asynchronous, active-high reset
Num_A_in  input  3  operand A, sampled only on accepted start
Num_B_in  input  3  operand B, sampled only on accepted start
start_in  input  1  request a sequence; level-sampled, acted on only in IDLE
abort_in  input  1  terminate sequence, return to IDLE
man_in  input  1  1 = manual stepping, 0 = auto dwell
step_in  input  1  manual advance; rising edge detected internally (synchronous)
Num_A_out  output  3  latched operand A to ALU
Num_B_out  output  3  latched operand B to ALU
Sel_A_out  output  2  ALU operation select
Sel_M_out  output  1  display mux select: 0 octal, 1 Gray
busy_out  output  1  sequence in progress
done_out  output  1  one-cycle pulse on sequence completion
phase_out  output  3  current phase index {Sel_A_out, Sel_M_out}

Behaviour:
- Clock and reset: one clock domain, clk_in. Reset is asynchronous and active-high on rst_in.
- Reset values: every output is 0, the FSM is in IDLE, the dwell counter is 0, and the step edge-detect register is 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_in=1 and abort_in=0 at an edge → capture Num_A_in/Num_B_in, phase=0, counter=0, go to RUN.
  - busy_out=1 from that same edge.
- RUN:
  - phase 0..7; Sel_A_out=phase[2:1], Sel_M_out=phase[0].
  - Order: op0 octal, op0 Gray, op1 octal, …, op3 Gray.
- Auto mode (man_in=0):
  - Counter increments each cycle.
  - When counter==DWELL-1: counter→0, phase+1.
  - Each phase is visible for exactly DWELL cycles.
- Manual mode (man_in=1):
  - Counter is held at 0.
  - Phase advances on the cycle after a detected 0→1 of step_in.
  - Holding step_in high advances only once.
- Switching man_in mid-phase:
  - auto→manual: counter clears to 0.
  - manual→auto: counting starts from 0.
- Last phase: advance out of phase 7 → DONE.
- DONE:
  - Lasts one cycle: done_out=1, busy_out=0, Sel outputs and operands hold their last values.
  - Then IDLE with done_out=0.
  - Total auto sequence: 8×DWELL RUN cycles + 1 DONE cycle.
- IDLE outputs: Sel_A_out, Sel_M_out, phase_out and operands hold their last values (0 after reset).
- Abort:
  - abort_in=1 in RUN or DONE → IDLE at the next edge.
  - busy_out=0, no done_out pulse, phase_out=0, Sel outputs=0; operands keep their values.
- Simultaneous events:
  - abort_in and start_in together in IDLE: start is rejected.
  - start_in while RUN/DONE: ignored; operands are not re-captured.
  - Operand input changes during RUN: no effect on outputs.
- start_in held high after DONE → a new sequence starts on the first IDLE edge, re-capturing operands.
- Reset mid-operation: outputs clear immediately (asynchronously), with no done pulse.

Test Plan:
- Reset then idle: assert rst_in mid-cycle → all outputs 0 immediately; 20 idle cycles with no start → outputs stay 0.
- Auto sequence, DWELL=4: A=5, B=3, start pulse → busy_out=1 next edge; phase_out 0..7 each held 4 cycles; Sel_A_out 0,0,1,1,2,2,3,3; Sel_M_out alternating 0,1; done_out high exactly at cycle 33 after start, busy_out 0.
- Operand isolation: change Num_A_in to 7 and pulse start_in at phase 3 → Num_A_out stays 5, phase sequence undisturbed.
- Manual mode: man_in=1, start → phase stays 0 for 50 cycles; step_in high for 5 cycles → phase 1 only; 7 further step pulses → done_out pulse after the 8th advance.
- Abort and contention: abort_in at phase 4 → next edge IDLE, busy_out=0, phase_out=0, no done_out. start_in and abort_in together in IDLE → remains IDLE.
- Reset mid-run: rst_in asserted at phase 5, counter 2 → outputs 0 asynchronously; after release, a new start produces a full clean sequence from phase 0.
